// File: rtl/bht_update_queue.sv
// Branch-history-table update queue.
// Accepts up to two resolved branches per cycle, in program order, and drains
// one entry per cycle into the BHT write port.
module bht_update_queue #(
  parameter int unsigned DEPTH              = 8,
  parameter int unsigned PTR_WIDTH          = 3,
  parameter int unsigned BHTBTB_INDEX_WIDTH = 9
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          upd0_valid,
  input  logic [63:0]                   upd0_pc,
  input  logic                          upd0_taken,
  input  logic                          upd1_valid,
  input  logic [63:0]                   upd1_pc,
  input  logic                          upd1_taken,
  output logic                          upd_ready,
  output logic                          bht_write_enable,
  output logic [BHTBTB_INDEX_WIDTH-1:0] bht_write_index,
  output logic [1:0]                    bht_write_counter_select,
  output logic                          bht_write_inc,
  output logic                          bht_write_dec,
  output logic                          bht_valid_in,
  output logic [PTR_WIDTH:0]            queue_count,
  output logic [31:0]                   bht_update_count
);

  localparam int unsigned CNT_W = PTR_WIDTH + 1;
  localparam int unsigned IDX_W = BHTBTB_INDEX_WIDTH;
  // Entry layout: {index, counter select, taken}
  localparam int unsigned ENT_W = IDX_W + 3;

  logic [ENT_W-1:0]     mem_q [DEPTH];
  logic [PTR_WIDTH-1:0] head_q, head_d;
  logic [PTR_WIDTH-1:0] tail_q, tail_d, tail_p1;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [31:0]          upd_cnt_q, upd_cnt_d;

  logic             enq0, enq1, deq;
  logic [ENT_W-1:0] ent0, ent1;
  logic             wr_a_en, wr_b_en;
  logic [ENT_W-1:0] wr_a_data, wr_b_data;
  logic [ENT_W-1:0] head_ent;

  // PC bits outside the index/select fields carry no BHT information
  logic unused_pc_bits;
  assign unused_pc_bits = ^{upd0_pc[63:IDX_W+4], upd0_pc[1:0],
                            upd1_pc[63:IDX_W+4], upd1_pc[1:0]};

  // Two free slots are needed so a dual update is never split
  assign upd_ready = (count_q <= CNT_W'(DEPTH - 2));

  // Enqueue/dequeue decisions and next pointer/count values
  always_comb begin
    ent0      = {upd0_pc[IDX_W+3:4], upd0_pc[3:2], upd0_taken};
    ent1      = {upd1_pc[IDX_W+3:4], upd1_pc[3:2], upd1_taken};
    enq0      = upd_ready & upd0_valid;
    enq1      = upd_ready & upd1_valid;
    deq       = (count_q != '0);
    tail_p1   = tail_q + PTR_WIDTH'(1);
    wr_a_en   = enq0 | enq1;
    wr_a_data = enq0 ? ent0 : ent1;
    wr_b_en   = enq0 & enq1;
    wr_b_data = ent1;
    tail_d    = tail_q + PTR_WIDTH'(enq0) + PTR_WIDTH'(enq1);
    head_d    = head_q + PTR_WIDTH'(deq);
    count_d   = count_q + CNT_W'(enq0) + CNT_W'(enq1) - CNT_W'(deq);
    upd_cnt_d = upd_cnt_q + 32'(deq);
  end

  // Pointer, occupancy and drain-counter registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      upd_cnt_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      upd_cnt_q <= upd_cnt_d;
    end
  end

  // Entry storage; payloads are qualified by count so they need no reset
  always_ff @(posedge clock) begin
    if (wr_a_en) mem_q[tail_q]  <= wr_a_data;
    if (wr_b_en) mem_q[tail_p1] <= wr_b_data;
  end

  // BHT write port driven from the head entry, forced to zero when empty
  always_comb begin
    head_ent                 = mem_q[head_q];
    bht_write_enable         = deq;
    bht_valid_in             = deq;
    bht_write_index          = '0;
    bht_write_counter_select = '0;
    bht_write_inc            = 1'b0;
    bht_write_dec            = 1'b0;
    if (deq) begin
      bht_write_index          = head_ent[ENT_W-1:3];
      bht_write_counter_select = head_ent[2:1];
      bht_write_inc            = head_ent[0];
      bht_write_dec            = ~head_ent[0];
    end
  end

  assign queue_count      = count_q;
  assign bht_update_count = upd_cnt_q;

endmodule

// File: tb/tb_bht_update_queue.sv
// Self-checking bench for bht_update_queue against a queue-based reference model.
module tb_bht_update_queue;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned PW    = 3;
  localparam int unsigned IW    = 9;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          upd0_valid, upd0_taken, upd1_valid, upd1_taken;
  logic [63:0]   upd0_pc, upd1_pc;
  logic          upd_ready, bht_write_enable, bht_write_inc, bht_write_dec, bht_valid_in;
  logic [IW-1:0] bht_write_index;
  logic [1:0]    bht_write_counter_select;
  logic [PW:0]   queue_count;
  logic [31:0]   bht_update_count;

  bht_update_queue #(.DEPTH(DEPTH), .PTR_WIDTH(PW), .BHTBTB_INDEX_WIDTH(IW)) dut (
    .clock(clock), .reset_n(reset_n),
    .upd0_valid(upd0_valid), .upd0_pc(upd0_pc), .upd0_taken(upd0_taken),
    .upd1_valid(upd1_valid), .upd1_pc(upd1_pc), .upd1_taken(upd1_taken),
    .upd_ready(upd_ready), .bht_write_enable(bht_write_enable),
    .bht_write_index(bht_write_index), .bht_write_counter_select(bht_write_counter_select),
    .bht_write_inc(bht_write_inc), .bht_write_dec(bht_write_dec),
    .bht_valid_in(bht_valid_in), .queue_count(queue_count),
    .bht_update_count(bht_update_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [1:0]    sel;
    logic          tkn;
  } ent_t;

  ent_t        mq[$];
  int unsigned m_upd_cnt;
  int          n_checks;
  int          n_fail;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t mk(input logic [63:0] pc, input logic t);
    ent_t e;
    e.idx = IW'((pc / 64'd16) % 64'd512);
    e.sel = 2'((pc / 64'd4) % 64'd4);
    e.tkn = t;
    return e;
  endfunction

  // Compare every DUT output with what the model says it should be
  task automatic check_outputs(input string ph);
    ent_t h;
    bit   ne;
    ne = (mq.size() != 0);
    h  = ne ? mq[0] : '0;
    check_eq({ph, "_ready"}, 64'(upd_ready), 64'((DEPTH - mq.size()) >= 2));
    check_eq({ph, "_count"}, 64'(queue_count), 64'(mq.size()));
    check_eq({ph, "_wen"}, 64'(bht_write_enable), 64'(ne));
    check_eq({ph, "_vin"}, 64'(bht_valid_in), 64'(ne));
    check_eq({ph, "_idx"}, 64'(bht_write_index), 64'(h.idx));
    check_eq({ph, "_sel"}, 64'(bht_write_counter_select), 64'(h.sel));
    check_eq({ph, "_inc"}, 64'(bht_write_inc), 64'(ne && h.tkn));
    check_eq({ph, "_dec"}, 64'(bht_write_dec), 64'(ne && !h.tkn));
    check_eq({ph, "_updcnt"}, 64'(bht_update_count), 64'(m_upd_cnt));
  endtask

  task automatic drive(input logic v0, input logic [63:0] p0, input logic t0,
                       input logic v1, input logic [63:0] p1, input logic t1);
    upd0_valid = v0; upd0_pc = p0; upd0_taken = t0;
    upd1_valid = v1; upd1_pc = p1; upd1_taken = t1;
  endtask

  // Advance the model across one edge, clock the DUT, then compare
  task automatic step(input string ph);
    bit rdy;
    rdy = (DEPTH - mq.size()) >= 2;
    if (mq.size() != 0) begin
      void'(mq.pop_front());
      m_upd_cnt++;
    end
    if (rdy && upd0_valid) mq.push_back(mk(upd0_pc, upd0_taken));
    if (rdy && upd1_valid) mq.push_back(mk(upd1_pc, upd1_taken));
    @(posedge clock);
    @(negedge clock);
    check_outputs(ph);
  endtask

  function automatic logic [63:0] rpc();
    return {$urandom, $urandom};
  endfunction

  initial begin
    n_checks = 0; n_fail = 0; m_upd_cnt = 0;
    reset_n = 1'b0;
    drive(0, 64'h0, 0, 0, 64'h0, 0);
    @(negedge clock);
    check_outputs("rst");
    @(negedge clock);
    reset_n = 1'b1;
    step("idle");

    // Single slot-0 update with a known PC
    drive(1, 64'h1234, 1, 0, 64'h0, 0);
    step("r36a");
    drive(0, 64'h0, 0, 0, 64'h0, 0);
    check_eq("r36_wen", 64'(bht_write_enable), 64'd1);
    check_eq("r36_idx", 64'(bht_write_index), 64'h123);
    check_eq("r36_sel", 64'(bht_write_counter_select), 64'd1);
    check_eq("r36_inc", 64'(bht_write_inc), 64'd1);
    check_eq("r36_dec", 64'(bht_write_dec), 64'd0);
    step("r36b");
    check_eq("r36_wen_off", 64'(bht_write_enable), 64'd0);
    check_eq("r36_updcnt", 64'(bht_update_count), 64'd1);

    // Dual updates every cycle until the queue backs up, then drain
    for (int i = 0; i < 12; i++) begin
      drive(1, rpc(), 1'($urandom), 1, rpc(), 1'($urandom));
      step("r37");
      if (queue_count == 4'd7)
        check_eq("r37_ready_at7", 64'(upd_ready), 64'd0);
    end
    drive(0, 64'h0, 0, 0, 64'h0, 0);
    for (int i = 0; i < 10; i++) step("r37d");

    // Burst of six single updates with alternating direction
    for (int i = 0; i < 6; i++) begin
      drive(1, rpc(), 1'(i % 2), 0, 64'h0, 0);
      step("r38");
    end
    drive(0, 64'h0, 0, 0, 64'h0, 0);
    for (int i = 0; i < 3; i++) step("r38d");
    check_eq("r38_empty", 64'(queue_count), 64'd0);

    // Slot-1-only update, then a dual update to check ordering
    drive(0, rpc(), 1, 1, 64'h0000_0000_0000_5678, 0);
    step("r39a");
    check_eq("r39_dec", 64'(bht_write_dec), 64'd1);
    drive(1, 64'h0000_0000_0000_0ABC, 1, 1, 64'h0000_0000_0000_0DE8, 0);
    step("r39b");
    drive(0, 64'h0, 0, 0, 64'h0, 0);
    for (int i = 0; i < 3; i++) step("r39d");

    // Reset between clock edges with five entries queued
    for (int i = 0; i < 4; i++) begin
      drive(1, rpc(), 1'($urandom), 1, rpc(), 1'($urandom));
      step("r40f");
    end
    drive(0, 64'h0, 0, 0, 64'h0, 0);
    check_eq("r40_count5", 64'(queue_count), 64'd5);
    #2 reset_n = 1'b0;
    #1;
    mq.delete();
    m_upd_cnt = 0;
    check_outputs("r40_async");
    @(negedge clock);
    check_outputs("r40_hold");
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) step("r40_post");

    // Long random run with sender holding inputs while not ready
    drive(0, 64'h0, 0, 0, 64'h0, 0);
    for (int i = 0; i < 400; i++) begin
      if (upd_ready)
        drive(($urandom % 10) < 6, rpc(), 1'($urandom), ($urandom % 10) < 6, rpc(), 1'($urandom));
      step("rnd");
    end
    drive(0, 64'h0, 0, 0, 64'h0, 0);
    for (int i = 0; i < DEPTH + 2; i++) step("rnd_drain");
    check_eq("final_empty", 64'(queue_count), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bht_update_queue.md
BHT_UPDATE_QUEUE -- requirements
Module: bht_update_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning the number of queue entries (power of two, at least 4).
REQ-002 SHALL have parameter PTR_WIDTH, default 3, meaning log2(DEPTH).
REQ-003 SHALL have parameter BHTBTB_INDEX_WIDTH, default 9, meaning the BHT set index width.
REQ-004 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port upd0_valid  input  1  resolved-branch update on slot 0 (older).
REQ-007 SHALL have port upd0_pc  input  64  PC of slot-0 branch.
REQ-008 SHALL have port upd0_taken  input  1  resolved direction of slot-0 branch.
REQ-009 SHALL have ports upd1_valid, upd1_pc, upd1_taken  input  1/64/1  same meaning as slot 0, for the younger slot.
REQ-010 SHALL have port upd_ready  output  1  queue accepts both slots this cycle.
REQ-011 SHALL have port bht_write_enable  output  1  drives the BHT write enable.
REQ-012 SHALL have port bht_write_index  output  BHTBTB_INDEX_WIDTH  drives the BHT set index.
REQ-013 SHALL have port bht_write_counter_select  output  2  drives the BHT counter select.
REQ-014 SHALL have ports bht_write_inc and bht_write_dec  output  1 each  drive the BHT counter direction.
REQ-015 SHALL have port bht_valid_in  output  1  drives the BHT valid-bit write value.
REQ-016 SHALL have port queue_count  output  PTR_WIDTH+1  current occupancy.
REQ-017 SHALL have port bht_update_count  output  32  total entries drained to the BHT.

Function
REQ-018 SHALL be a circular FIFO: head pointer and tail pointer are PTR_WIDTH bits each and wrap modulo DEPTH; the count register is PTR_WIDTH+1 bits.
REQ-019 SHALL store per entry: index = pc[BHTBTB_INDEX_WIDTH+3:4], select = pc[3:2], taken.
REQ-020 SHALL drive upd_ready = (DEPTH - count) >= 2, combinationally from registered count only.
REQ-021 SHALL, when upd_ready=1, enqueue every valid slot in the same edge; both valid means slot 0 at tail and slot 1 at tail+1, and tail advances by 2.
REQ-022 SHALL, when only upd1_valid=1, enqueue slot 1 at tail; tail advances by 1.
REQ-023 SHALL ignore all update inputs when upd_ready=0; the sender holds them, and nothing is dropped or counted.
REQ-024 SHALL drive bht_write_enable = (count != 0) combinationally from registered state; index, select, inc=taken and dec=!taken come from the head entry.
REQ-025 SHALL hold bht_valid_in at 1 whenever bht_write_enable=1, and at 0 otherwise.
REQ-026 SHALL drive all bht_write_* outputs to 0 while count = 0.
REQ-027 SHALL dequeue one entry on every edge where count != 0, because the BHT write port never stalls; head advances by 1.
REQ-028 SHALL update count as count + enqueued - dequeued on a single edge, with enqueue and dequeue allowed in the same cycle.
REQ-029 SHALL have enqueue-to-write latency of exactly 1 cycle when the queue was empty, with no same-cycle bypass.
REQ-030 SHALL drain entries in strict program order: slot 0 before slot 1, and earlier cycles before later ones.
REQ-031 SHALL increment bht_update_count by 1 per dequeue, wrapping from 2^32-1 to 0.
REQ-032 SHALL never overflow or underflow; count stays within 0..DEPTH by construction.

Reset
REQ-033 SHALL, while reset_n=0 and independent of clock, clear the head, tail, count and bht_update_count registers.
REQ-034 SHALL, during reset, present upd_ready=1, bht_write_enable=0 and all other bht_write_* outputs at 0.
REQ-035 SHALL, on reset mid-operation, discard all pending entries; entry payloads need no reset.

Verification
REQ-036 SHALL cover: after reset, a single upd0 with pc=0x1234 and taken=1 -> next cycle bht_write_enable=1, index=0x123, select=1, inc=1, dec=0; the cycle after, enable=0 and bht_update_count=1.
REQ-037 SHALL cover: dual updates every cycle, DEPTH=8 -> count rises by 1 per cycle, upd_ready drops at count=7, and inputs are ignored while ready=0.
REQ-038 SHALL cover: a burst of 6 updates with alternating taken, then idle -> 6 consecutive write cycles in order with inc/dec alternating, and count returns to 0.
REQ-039 SHALL cover: upd1_valid only, with upd0_valid=0 and taken=0 -> one entry with dec=1, and slot order is preserved on the next dual enqueue.
REQ-040 SHALL cover: reset_n asserted with count=5, between clock edges -> count=0, bht_write_enable=0 and upd_ready=1 immediately, and no stale entry is written after release.
REQ-041 SHALL cover: pointer wrap after more than 3*DEPTH entries -> drained sequence matches the enqueued sequence exactly.
